// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM waveform stage.
// The dead-time FSM states are only used when PWM_DEADTIME_EN is defined.
package pwm_pkg;

  localparam int PWM_N          = 16;
  localparam int PWM_PRESCALE_W = 8;
  localparam int PWM_DT_W       = 8;

  typedef enum logic [2:0] {
    DT_OFF,
    DT_RISE,
    DT_ON,
    DT_FALL,
    DT_OFF_L
  } dt_state_t;

endpackage

// File: rtl/pwm_deadtime.sv
// Output stage for the complementary pin pair: dead-time FSM when PWM_DEADTIME_EN
// is defined, otherwise a registered pass-through with pwm_l as the complement.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = PWM_DT_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            raw,
  input  logic [DT_W-1:0] dt_in,
  output logic            pwm_h,
  output logic            pwm_l
);

`ifdef PWM_DEADTIME_EN

  dt_state_t       state, state_n;
  logic [DT_W-1:0] dt_cnt, dt_cnt_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= DT_OFF;
      dt_cnt <= '0;
    end else begin
      state  <= state_n;
      dt_cnt <= dt_cnt_n;
    end
  end

  // A zero dead-time skips the gap states so the waveform matches the plain build.
  always_comb begin
    state_n  = state;
    dt_cnt_n = dt_cnt;
    if (!enable) begin
      state_n = DT_OFF;
    end else begin
      case (state)
        DT_OFF, DT_OFF_L: begin
          if (raw) begin
            if (dt_in == '0) state_n = DT_ON;
            else begin
              state_n  = DT_RISE;
              dt_cnt_n = dt_in - DT_W'(1);
            end
          end else if (state == DT_OFF) begin
            if (dt_in == '0) state_n = DT_OFF_L;
            else begin
              state_n  = DT_FALL;
              dt_cnt_n = dt_in - DT_W'(1);
            end
          end
        end
        DT_RISE: begin
          if (!raw)                state_n = DT_OFF;
          else if (dt_cnt == '0)   state_n = DT_ON;
          else                     dt_cnt_n = dt_cnt - DT_W'(1);
        end
        DT_ON: begin
          if (!raw) begin
            if (dt_in == '0) state_n = DT_OFF_L;
            else begin
              state_n  = DT_FALL;
              dt_cnt_n = dt_in - DT_W'(1);
            end
          end
        end
        DT_FALL: begin
          if (raw) begin
            if (dt_in == '0) state_n = DT_ON;
            else begin
              state_n  = DT_RISE;
              dt_cnt_n = dt_in - DT_W'(1);
            end
          end else if (dt_cnt == '0) begin
            state_n = DT_OFF_L;
          end else begin
            dt_cnt_n = dt_cnt - DT_W'(1);
          end
        end
        default: state_n = DT_OFF;
      endcase
    end
  end

  assign pwm_h = (state == DT_ON);
  assign pwm_l = (state == DT_OFF_L);

`else

  logic unused_dt;
  assign unused_dt = ^dt_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else begin
      pwm_h <= raw;
      pwm_l <= enable & ~raw;
    end
  end

`endif

endmodule

// File: rtl/pwm_wave_gen.sv
// PWM waveform stage: double-buffered period/duty/prescale, prescaled period counter,
// compare and end-of-period tick. Define PWM_DEADTIME_EN for dead-time insertion.
module pwm_wave_gen
  import pwm_pkg::*;
#(
  parameter int N          = PWM_N,
  parameter int PRESCALE_W = PWM_PRESCALE_W,
  parameter int DT_W       = PWM_DT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [N-1:0]          period_in,
  input  logic [N-1:0]          duty_in,
  input  logic [PRESCALE_W-1:0] prescale_in,
  input  logic [DT_W-1:0]       dt_in,
  output logic                  pwm_h,
  output logic                  pwm_l,
  output logic                  period_tick,
  output logic                  update_pending,
  output logic [N-1:0]          count
);

  logic [N-1:0]          period_act, duty_act, period_sh, duty_sh;
  logic [PRESCALE_W-1:0] prescale_act, prescale_sh, pre_cnt;
  logic                  tick, boundary, raw;

  always_comb begin
    tick     = (pre_cnt == prescale_act);
    boundary = tick && (count == period_act);
    raw      = enable && (count < duty_act);
  end

  // A load landing on the boundary bypasses the shadow and discards its old contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      period_act     <= '0;
      duty_act       <= '0;
      prescale_act   <= '0;
      period_sh      <= '0;
      duty_sh        <= '0;
      prescale_sh    <= '0;
      pre_cnt        <= '0;
      count          <= '0;
      period_tick    <= 1'b0;
      update_pending <= 1'b0;
    end else if (!enable) begin
      pre_cnt        <= '0;
      count          <= '0;
      period_tick    <= 1'b0;
      update_pending <= 1'b0;
      if (load) begin
        period_act   <= period_in;
        duty_act     <= duty_in;
        prescale_act <= prescale_in;
      end
    end else begin
      period_tick <= boundary;
      if (tick) begin
        pre_cnt <= '0;
        count   <= boundary ? '0 : count + N'(1);
      end else begin
        pre_cnt <= pre_cnt + PRESCALE_W'(1);
      end
      if (load && boundary) begin
        period_act     <= period_in;
        duty_act       <= duty_in;
        prescale_act   <= prescale_in;
        update_pending <= 1'b0;
      end else if (load) begin
        period_sh      <= period_in;
        duty_sh        <= duty_in;
        prescale_sh    <= prescale_in;
        update_pending <= 1'b1;
      end else if (boundary && update_pending) begin
        period_act     <= period_sh;
        duty_act       <= duty_sh;
        prescale_act   <= prescale_sh;
        update_pending <= 1'b0;
      end
    end
  end

  pwm_deadtime #(.DT_W(DT_W)) u_deadtime (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .raw    (raw),
    .dt_in  (dt_in),
    .pwm_h  (pwm_h),
    .pwm_l  (pwm_l)
  );

endmodule

// File: tb/tb_pwm_wave_gen.sv
// Directed self-checking bench for pwm_wave_gen: reset, basic waveform, shadow update,
// duty/period edge cases, prescaler and (with PWM_DEADTIME_EN) dead-time gaps.
module tb_pwm_wave_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] period_in;
  logic [15:0] duty_in;
  logic [7:0]  prescale_in;
  logic [7:0]  dt_in;
  logic        pwm_h;
  logic        pwm_l;
  logic        period_tick;
  logic        update_pending;
  logic [15:0] count;

  int checks = 0;
  int errors = 0;
  int hi_cnt;
  int tk_cnt;
  int duty_exp;

  always #5 clock = ~clock;

  pwm_wave_gen dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .load           (load),
    .period_in      (period_in),
    .duty_in        (duty_in),
    .prescale_in    (prescale_in),
    .dt_in          (dt_in),
    .pwm_h          (pwm_h),
    .pwm_l          (pwm_l),
    .period_tick    (period_tick),
    .update_pending (update_pending),
    .count          (count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic ld, input logic [15:0] per,
                               input logic [15:0] dty, input logic [7:0] pre,
                               input logic [7:0] dt);
    enable      = en;
    load        = ld;
    period_in   = per;
    duty_in     = dty;
    prescale_in = pre;
    dt_in       = dt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_h"},     32'(pwm_h),          32'd0);
    checkOutput({tag, "_l"},     32'(pwm_l),          32'd0);
    checkOutput({tag, "_tick"},  32'(period_tick),    32'd0);
    checkOutput({tag, "_pend"},  32'(update_pending), 32'd0);
    checkOutput({tag, "_count"}, 32'(count),          32'd0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 8'd0);
    step();
    step();
    checkAllZero("reset_init");
    reset = 1'b0;

    // Basic waveform (period 10, duty 3), then shadowed duty change to 7 at count 4
    applyStimulus(1'b0, 1'b1, 16'd9, 16'd3, 8'd0, 8'd0);
    step();
    checkOutput("direct_load_pend", 32'(update_pending), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'd9, 16'd3, 8'd0, 8'd0);
    hi_cnt = 0;
    tk_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      duty_exp = (k >= 30) ? 7 : 3;
      checkOutput("basic_count", 32'(count),          32'((k + 1) % 10));
      checkOutput("basic_h",     32'(pwm_h),          32'((k % 10) < duty_exp));
      checkOutput("basic_l",     32'(pwm_l),          32'((k % 10) >= duty_exp));
      checkOutput("basic_tick",  32'(period_tick),    32'((k % 10) == 9));
      checkOutput("shadow_pend", 32'(update_pending), 32'(k >= 24 && k <= 28));
      if (k < 20 && pwm_h) hi_cnt++;
      if (k < 20 && period_tick) tk_cnt++;
      if (k == 23) applyStimulus(1'b1, 1'b1, 16'd9, 16'd7, 8'd0, 8'd0);
      else         applyStimulus(1'b1, 1'b0, 16'd9, 16'd7, 8'd0, 8'd0);
    end
    checkOutput("basic_hi_total",   32'(hi_cnt), 32'd6);
    checkOutput("basic_tick_total", 32'(tk_cnt), 32'd2);

    // Reset asserted mid-run for three clocks
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkAllZero("reset_mid");
    end
    reset = 1'b0;
    enable = 1'b0;
    step();
    checkAllZero("post_reset");

    // duty 0 gives constant low
    applyStimulus(1'b0, 1'b1, 16'd9, 16'd0, 8'd0, 8'd0);
    step();
    applyStimulus(1'b1, 1'b0, 16'd9, 16'd0, 8'd0, 8'd0);
    for (int k = 0; k < 20; k++) begin
      step();
      checkOutput("duty0_h", 32'(pwm_h), 32'd0);
      checkOutput("duty0_l", 32'(pwm_l), 32'd1);
    end

    // duty above period gives constant high
    applyStimulus(1'b0, 1'b1, 16'd9, 16'd12, 8'd0, 8'd0);
    step();
    checkOutput("disable_forces_l", 32'(pwm_l), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'd9, 16'd12, 8'd0, 8'd0);
    for (int k = 0; k < 20; k++) begin
      step();
      checkOutput("dutybig_h", 32'(pwm_h), 32'd1);
      checkOutput("dutybig_l", 32'(pwm_l), 32'd0);
    end

    // period 0: every tick is a boundary
    applyStimulus(1'b0, 1'b1, 16'd0, 16'd1, 8'd0, 8'd0);
    step();
    applyStimulus(1'b1, 1'b0, 16'd0, 16'd1, 8'd0, 8'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      checkOutput("per0_h",     32'(pwm_h),       32'd1);
      checkOutput("per0_tick",  32'(period_tick), 32'd1);
      checkOutput("per0_count", 32'(count),       32'd0);
    end

    // Prescale 2: count steps every 3 clocks, 12-clock period, 6 clocks high
    applyStimulus(1'b0, 1'b1, 16'd3, 16'd2, 8'd2, 8'd0);
    step();
    applyStimulus(1'b1, 1'b0, 16'd3, 16'd2, 8'd2, 8'd0);
    hi_cnt = 0;
    tk_cnt = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      checkOutput("pre_count", 32'(count),       32'(((k + 1) / 3) % 4));
      checkOutput("pre_h",     32'(pwm_h),       32'(((k / 3) % 4) < 2));
      checkOutput("pre_tick",  32'(period_tick), 32'((k % 12) == 11));
      if (pwm_h) hi_cnt++;
      if (period_tick) tk_cnt++;
    end
    checkOutput("pre_hi_total",   32'(hi_cnt), 32'd12);
    checkOutput("pre_tick_total", 32'(tk_cnt), 32'd2);

    // Period 20, duty 10, dead-time 2
    applyStimulus(1'b0, 1'b1, 16'd19, 16'd10, 8'd0, 8'd2);
    step();
    applyStimulus(1'b1, 1'b0, 16'd19, 16'd10, 8'd0, 8'd2);
    hi_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
`ifdef PWM_DEADTIME_EN
      checkOutput("dt_h", 32'(pwm_h), 32'((k % 20) >= 2 && (k % 20) < 10));
      checkOutput("dt_l", 32'(pwm_l), 32'((k % 20) >= 12));
`else
      checkOutput("dt_h", 32'(pwm_h), 32'((k % 20) < 10));
      checkOutput("dt_l", 32'(pwm_l), 32'((k % 20) >= 10));
`endif
      checkOutput("no_overlap", 32'(pwm_h & pwm_l), 32'd0);
      if (k < 20 && pwm_h) hi_cnt++;
    end
`ifdef PWM_DEADTIME_EN
    checkOutput("dt_hi_total", 32'(hi_cnt), 32'd8);
`else
    checkOutput("dt_hi_total", 32'(hi_cnt), 32'd10);
`endif

    // enable dropping mid-period zeroes counters and outputs on the next edge
    step();
    step();
    step();
    enable = 1'b0;
    step();
    checkAllZero("disable_mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
